// File: rtl/ifft8_serial.sv
// ifft8_serial: streaming 8-point inverse DFT, one complex MAC per cycle.
// Latency: first sample 9 cycles after the 8th input beat, each later sample 9 cycles after the previous output handshake.
// Backpressure: in_ready only while loading (no frame overlap); outputs held stable while out_valid && !out_ready.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     bin handshake; in_re/in_im carry X[k], k = 0..7 in order
//   out_valid/out_ready   sample handshake; out_re/out_im carry x[n], out_last marks n = 7
//
// Build option: define IFFT8_ROUND_EN for round-half-up on the final scaling
// (default build truncates toward minus infinity). Timing is identical either way.
module ifft8_serial #(
    parameter int DW    = 8,
    parameter int ACC_W = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_re,
    input  logic [DW-1:0] in_im,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_re,
    output logic [DW-1:0] out_im,
    output logic          out_last
);

    // Twiddles are Q1.6 (64 == 1.0) and need 8 signed bits to hold +/-64.
    localparam int TW = 8;
    localparam int PW = DW + TW;
    // 1/8 normalisation (3 bits) plus removal of the Q1.6 twiddle scale (6 bits).
    localparam int SHIFT = 9;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 <<< (DW - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(1 <<< (DW - 1)));

`ifdef IFFT8_ROUND_EN
    // Half an output LSB, added before the shift for round-half-up.
    localparam logic signed [ACC_W-1:0] RND = ACC_W'(1 <<< (SHIFT - 1));
`else
    localparam logic signed [ACC_W-1:0] RND = '0;
`endif

    typedef enum logic [1:0] {
        S_LOAD,
        S_MAC,
        S_EMIT
    } state_t;

    // cos(2*pi*m/8) in Q1.6.
    function automatic logic signed [TW-1:0] tw_cos(input logic [2:0] m);
        case (m)
            3'd0:    tw_cos = 8'sd64;
            3'd1:    tw_cos = 8'sd45;
            3'd2:    tw_cos = 8'sd0;
            3'd3:    tw_cos = -8'sd45;
            3'd4:    tw_cos = -8'sd64;
            3'd5:    tw_cos = -8'sd45;
            3'd6:    tw_cos = 8'sd0;
            default: tw_cos = 8'sd45;
        endcase
    endfunction

    // Clamp a shifted accumulator into the signed DW-bit output range.
    function automatic logic [DW-1:0] sat(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX) begin
            sat = SAT_MAX[DW-1:0];
        end else if (v < SAT_MIN) begin
            sat = SAT_MIN[DW-1:0];
        end else begin
            sat = v[DW-1:0];
        end
    endfunction

    state_t                  state_q;
    logic [2:0]              k_q;
    logic [2:0]              n_q;
    logic signed [ACC_W-1:0] acc_re_q;
    logic signed [ACC_W-1:0] acc_im_q;
    logic                    out_valid_q;
    logic [DW-1:0]           out_re_q;
    logic [DW-1:0]           out_im_q;
    logic                    out_last_q;

    logic [DW-1:0]           buf_re_q [8];
    logic [DW-1:0]           buf_im_q [8];

    // MAC datapath
    logic [2:0]              m;
    logic signed [DW-1:0]    xr;
    logic signed [DW-1:0]    xi;
    logic signed [TW-1:0]    c;
    logic signed [TW-1:0]    s;
    logic signed [PW-1:0]    p_rc;
    logic signed [PW-1:0]    p_is;
    logic signed [PW-1:0]    p_rs;
    logic signed [PW-1:0]    p_ic;
    logic signed [ACC_W-1:0] term_re;
    logic signed [ACC_W-1:0] term_im;
    logic signed [ACC_W-1:0] acc_re_d;
    logic signed [ACC_W-1:0] acc_im_d;

    // Output scaling
    logic signed [ACC_W-1:0] rnd_re;
    logic signed [ACC_W-1:0] rnd_im;
    logic signed [ACC_W-1:0] sh_re;
    logic signed [ACC_W-1:0] sh_im;
    logic [DW-1:0]           out_re_d;
    logic [DW-1:0]           out_im_d;

    assign in_ready = (state_q == S_LOAD);

    always_comb begin
        // Only the low 3 bits of n*k matter: the twiddle index is taken mod 8.
        m  = n_q * k_q;
        xr = $signed(buf_re_q[k_q]);
        xi = $signed(buf_im_q[k_q]);
        c  = tw_cos(m);
        // sin(2*pi*m/8) is the cosine table rotated by a quarter turn.
        s  = tw_cos(m - 3'd2);

        p_rc = PW'(xr) * PW'(c);
        p_is = PW'(xi) * PW'(s);
        p_rs = PW'(xr) * PW'(s);
        p_ic = PW'(xi) * PW'(c);

        term_re = ACC_W'(p_rc) - ACC_W'(p_is);
        term_im = ACC_W'(p_rs) + ACC_W'(p_ic);

        // k == 0 starts a new sample, so the previous sum is dropped.
        if (k_q == 3'd0) begin
            acc_re_d = term_re;
            acc_im_d = term_im;
        end else begin
            acc_re_d = acc_re_q + term_re;
            acc_im_d = acc_im_q + term_im;
        end
    end

    always_comb begin
        rnd_re   = acc_re_q + RND;
        rnd_im   = acc_im_q + RND;
        sh_re    = rnd_re >>> SHIFT;
        sh_im    = rnd_im >>> SHIFT;
        out_re_d = sat(sh_re);
        out_im_d = sat(sh_im);
    end

    // Bin buffer, written only on an accepted input beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                buf_re_q[i] <= '0;
                buf_im_q[i] <= '0;
            end
        end else if (in_valid && in_ready) begin
            buf_re_q[k_q] <= in_re;
            buf_im_q[k_q] <= in_im;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_LOAD;
            k_q         <= '0;
            n_q         <= '0;
            acc_re_q    <= '0;
            acc_im_q    <= '0;
            out_valid_q <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            out_last_q  <= 1'b0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (in_valid) begin
                        k_q <= k_q + 3'd1;
                        if (k_q == 3'd7) begin
                            k_q     <= '0;
                            n_q     <= '0;
                            state_q <= S_MAC;
                        end
                    end
                end

                S_MAC: begin
                    acc_re_q <= acc_re_d;
                    acc_im_q <= acc_im_d;
                    // k wraps back to 0 after the 8th term, ready for the next sample.
                    k_q      <= k_q + 3'd1;
                    if (k_q == 3'd7) begin
                        state_q <= S_EMIT;
                    end
                end

                S_EMIT: begin
                    // The first EMIT cycle registers the finished sums; afterwards
                    // the sample is held until downstream takes it.
                    if (!out_valid_q) begin
                        out_re_q    <= out_re_d;
                        out_im_q    <= out_im_d;
                        out_last_q  <= (n_q == 3'd7);
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        k_q         <= '0;
                        if (n_q == 3'd7) begin
                            n_q     <= '0;
                            state_q <= S_LOAD;
                        end else begin
                            n_q     <= n_q + 3'd1;
                            state_q <= S_MAC;
                        end
                    end
                end

                default: begin
                    state_q <= S_LOAD;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_ifft8_serial.sv
// tb_ifft8_serial: directed frames for ifft8_serial with hand-computed samples.
// Frames: DC bin, single tone, saturating mix; then gaps, backpressure and mid-frame reset.
// Expected samples follow the floor or round-half-up build according to IFFT8_ROUND_EN.
module tb_ifft8_serial;

    localparam int DW    = 8;
    localparam int ACC_W = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_re;
    logic [DW-1:0] in_im;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_re;
    logic [DW-1:0] out_im;
    logic          out_last;

    ifft8_serial #(
        .DW   (DW),
        .ACC_W(ACC_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_re    (in_re),
        .in_im    (in_im),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_re   (out_re),
        .out_im   (out_im),
        .out_last (out_last)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string name;
        int    bre[8];
        int    bim[8];
        int    ere[8];
        int    eim[8];
    } vec_t;

    vec_t vecs[3];
    int   errors  = 0;
    int   checks  = 0;
    int   last_hs = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Waits (bounded) for out_valid; optionally checks in_ready stays low meanwhile.
    task automatic wait_valid(input string tag, input bit chk_ir, output bit ok);
        int t;
        t = 0;
        while (!out_valid && t < 20) begin
            if (chk_ir) chk({tag, " in_ready busy"}, int'(in_ready), 0);
            @(posedge clk);
            #1;
            t++;
        end
        ok = out_valid;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: out_valid not seen within 20 cycles", tag);
        end
    endtask

    task automatic send_frame(input int v, input bit gaps);
        for (int k = 0; k < 8; k++) begin
            in_re    = DW'(vecs[v].bre[k]);
            in_im    = DW'(vecs[v].bim[k]);
            in_valid = 1'b1;
            chk($sformatf("%s in_ready k%0d", vecs[v].name, k), int'(in_ready), 1);
            @(posedge clk);
            #1;
            if (gaps && k < 7) begin
                in_valid = 1'b0;
                in_re    = 8'h5a;
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
        last_hs  = cyc;
    endtask

    task automatic recv_frame(input int v, input int hold_n, input bit push_in);
        int    ref_cyc;
        int    hr;
        int    hi;
        bit    ok;
        string tag;
        ref_cyc = last_hs;
        for (int n = 0; n < 8; n++) begin
            tag       = $sformatf("%s n%0d", vecs[v].name, n);
            out_ready = (n == hold_n) ? 1'b0 : 1'b1;
            if (push_in && n < 7) begin
                in_valid = 1'b1;
                in_re    = 8'h11;
                in_im    = 8'h22;
            end else begin
                in_valid = 1'b0;
            end
            wait_valid(tag, push_in, ok);
            if (!ok) return;
            chk({tag, " latency"}, cyc - ref_cyc, 9);
            chk({tag, " re"}, int'($signed(out_re)), vecs[v].ere[n]);
            chk({tag, " im"}, int'($signed(out_im)), vecs[v].eim[n]);
            chk({tag, " last"}, int'(out_last), (n == 7) ? 1 : 0);
            if (n == hold_n) begin
                hr = int'($signed(out_re));
                hi = int'($signed(out_im));
                for (int i = 0; i < 5; i++) begin
                    @(posedge clk);
                    #1;
                    chk({tag, " held valid"}, int'(out_valid), 1);
                    chk({tag, " held re"}, int'($signed(out_re)), hr);
                    chk({tag, " held im"}, int'($signed(out_im)), hi);
                end
                out_ready = 1'b1;
            end
            @(posedge clk);
            #1;
            ref_cyc = cyc;
            chk({tag, " valid drops"}, int'(out_valid), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        bit ok;

        vecs[0].name = "dc";
        vecs[0].bre  = '{64, 0, 0, 0, 0, 0, 0, 0};
        vecs[0].bim  = '{0, 0, 0, 0, 0, 0, 0, 0};
        vecs[0].ere  = '{8, 8, 8, 8, 8, 8, 8, 8};
        vecs[0].eim  = '{0, 0, 0, 0, 0, 0, 0, 0};

        vecs[1].name = "tone";
        vecs[1].bre  = '{0, 64, 0, 0, 0, 0, 0, 0};
        vecs[1].bim  = '{0, 0, 0, 0, 0, 0, 0, 0};
`ifdef IFFT8_ROUND_EN
        vecs[1].ere  = '{8, 6, 0, -6, -8, -6, 0, 6};
        vecs[1].eim  = '{0, 6, 8, 6, 0, -6, -8, -6};
`else
        vecs[1].ere  = '{8, 5, 0, -6, -8, -6, 0, 5};
        vecs[1].eim  = '{0, 5, 8, 5, 0, -6, -8, -6};
`endif

        // Sums: re = {-192, 78540, -64, 0, 64, -13260, -64, 0}, im = {-192, 0, 64, 0, 64, 0, 64, 0}.
        vecs[2].name = "sat";
        vecs[2].bre  = '{127, 127, 0, -128, -128, -128, 0, 127};
        vecs[2].bim  = '{0, -128, -128, -128, 0, 127, 127, 127};
`ifdef IFFT8_ROUND_EN
        vecs[2].ere  = '{0, 127, 0, 0, 0, -26, 0, 0};
        vecs[2].eim  = '{0, 0, 0, 0, 0, 0, 0, 0};
`else
        vecs[2].ere  = '{-1, 127, -1, 0, 0, -26, -1, 0};
        vecs[2].eim  = '{-1, 0, 0, 0, 0, 0, 0, 0};
`endif

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_re     = '0;
        in_im     = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset out_re", int'(out_re), 0);
        chk("reset out_im", int'(out_im), 0);
        chk("reset out_last", int'(out_last), 0);
        chk("reset in_ready", int'(in_ready), 1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int v = 0; v < 3; v++) begin
            send_frame(v, 1'b0);
            recv_frame(v, -1, 1'b0);
        end

        // Input beats separated by idle cycles.
        send_frame(0, 1'b1);
        recv_frame(0, -1, 1'b0);

        // Stall sample 3 for five cycles while in_valid is pushed during MAC/EMIT.
        send_frame(1, 1'b0);
        recv_frame(1, 3, 1'b1);

        // Reset in the middle of computing sample 2.
        send_frame(0, 1'b0);
        for (int n = 0; n < 2; n++) begin
            wait_valid("rstmid", 1'b0, ok);
            @(posedge clk);
            #1;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rstmid pre out_valid", int'(out_valid), 0);
        chk("rstmid pre out_re", int'($signed(out_re)), 8);
        chk("rstmid pre in_ready", int'(in_ready), 0);
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid async out_valid", int'(out_valid), 0);
        chk("rstmid async out_re", int'(out_re), 0);
        chk("rstmid async out_im", int'(out_im), 0);
        chk("rstmid async in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rstmid after in_ready", int'(in_ready), 1);
        chk("rstmid after out_valid", int'(out_valid), 0);
        send_frame(0, 1'b0);
        recv_frame(0, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
